// File: rtl/kf_update_seq.sv
// kf_update_seq: scalar Kalman measurement-update sequencer driving an external arithmetic unit
module kf_update_seq #(
  parameter int W    = 24,
  parameter int FRAC = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_we,
  input  logic [1:0]   cfg_addr,
  input  logic [W-1:0] cfg_data,
  input  logic         meas_valid,
  input  logic [W-1:0] meas_z,
  output logic         meas_ready,
  output logic         au_start,
  output logic [W-1:0] au_R,
  output logic [W-1:0] au_S,
  output logic [W-1:0] au_Iimm,
  output logic [1:0]   au_op_sel,
  output logic [1:0]   au_mul_y_sel,
  input  logic [W-1:0] au_result,
  input  logic         au_done,
  output logic [W-1:0] x_out,
  output logic [W-1:0] p_out,
  output logic         out_valid,
  output logic         busy
);
  if (FRAC >= W - 1) begin : g_frac_chk
    $error("FRAC must leave at least one integer bit");
  end
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;
  localparam logic [1:0] OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_DIV = 2'b11;
  state_t state, state_nx;
  logic [2:0] step;
  logic [W-1:0] x, p, q, r, z, pp, s, k, inn, t;
  logic accept, wb;
  assign meas_ready   = (state == IDLE) && !cfg_we;
  assign accept       = meas_valid && meas_ready;
  assign wb           = (state == WAIT) && au_done;
  assign au_start     = state == ISSUE;
  assign out_valid    = state == OUT;
  assign busy         = state != IDLE;
  assign au_Iimm      = '0;
  assign au_mul_y_sel = 2'b00;
  assign x_out        = x;
  assign p_out        = p;
  // microprogram decode: operands and opcode follow the step counter only
  always_comb begin
    au_R      = p;
    au_S      = q;
    au_op_sel = OP_ADD;
    case (step)
      3'd0: begin au_R = p;  au_S = q;   au_op_sel = OP_ADD; end
      3'd1: begin au_R = pp; au_S = r;   au_op_sel = OP_ADD; end
      3'd2: begin au_R = pp; au_S = s;   au_op_sel = OP_DIV; end
      3'd3: begin au_R = z;  au_S = x;   au_op_sel = OP_SUB; end
      3'd4: begin au_R = k;  au_S = inn; au_op_sel = OP_MUL; end
      3'd5: begin au_R = x;  au_S = t;   au_op_sel = OP_ADD; end
      3'd6: begin au_R = k;  au_S = pp;  au_op_sel = OP_MUL; end
      default: begin au_R = pp; au_S = t; au_op_sel = OP_SUB; end
    endcase
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = accept ? ISSUE : IDLE;
      ISSUE:   state_nx = WAIT;
      WAIT:    state_nx = au_done ? ((step == 3'd7) ? OUT : ISSUE) : WAIT;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      step  <= '0;
      x     <= '0;
      p     <= '0;
      q     <= '0;
      r     <= '0;
      z     <= '0;
      pp    <= '0;
      s     <= '0;
      k     <= '0;
      inn   <= '0;
      t     <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && cfg_we)
        case (cfg_addr)
          2'd0:    x <= cfg_data;
          2'd1:    p <= cfg_data;
          2'd2:    q <= cfg_data;
          default: r <= cfg_data;
        endcase
      if (accept) begin
        z    <= meas_z;
        step <= '0;
      end
      if (wb) begin
        case (step)
          3'd0:       pp  <= au_result;
          3'd1:       s   <= au_result;
          3'd2:       k   <= au_result;
          3'd3:       inn <= au_result;
          3'd4, 3'd6: t   <= au_result;
          3'd5:       x   <= au_result;
          default:    p   <= au_result;
        endcase
        if (step != 3'd7) step <= step + 3'd1;
      end
    end
  end
endmodule

// File: doc/kf_update_seq.md
# kf_update_seq

Scalar Kalman measurement-update sequencer that sits directly upstream of the arithmetic unit `au`. It holds the filter state and tuning parameters, accepts one measurement per update, and issues a fixed 8-step microprogram to `au`. Each step drives operands, op_sel and start, waits for done, and writes the result back into its local register file. When the program finishes, it presents the updated state estimate and covariance.

## Interface
- `W`, 24: word width; all data is sign-magnitude, bit W-1 is the sign.
- `FRAC`, 14: fractional bits. Informational only; all scaling is done in `au`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `cfg_we` in 1: configuration write strobe.
- `cfg_addr` in 2: 0 = X, 1 = P, 2 = Q, 3 = R.
- `cfg_data` in W: configuration value.
- `meas_valid` in 1: measurement z offered.
- `meas_z` in W: measurement value.
- `meas_ready` out 1: the sequencer can accept a measurement.
- `au_start` out 1: one-cycle start pulse to `au`.
- `au_R`, `au_S`, `au_Iimm` out W: operands to `au`. `au_Iimm` is tied to 0.
- `au_op_sel` out 2: 00 ADD, 01 SUB, 10 MUL, 11 DIV.
- `au_mul_y_sel` out 2: constant 00.
- `au_result` in W: result from `au`.
- `au_done` in 1: one-cycle pulse from `au`.
- `x_out`, `p_out` out W: current X and P registers.
- `out_valid` out 1: one-cycle pulse when the update completes.
- `busy` out 1: high in every state except IDLE.

## Operation
- Register file: X, P, Q, R, Z, PP, S, K, INN, T, each W bits. All reset to 0.
- Config writes:
  - Honoured only in IDLE; ignored in other states.
  - `cfg_we` in IDLE forces `meas_ready` low in that cycle, so config has priority over a measurement.
- Measurement handshake:
  - `meas_ready` = (state == IDLE) && !`cfg_we`.
  - A transfer occurs on `meas_valid` && `meas_ready`. At that edge: Z <= `meas_z`, step <= 0, state -> ISSUE.
- Microprogram (step: op, R operand, S operand -> destination):
  - 0: ADD P, Q -> PP
  - 1: ADD PP, R -> S
  - 2: DIV PP, S -> K
  - 3: SUB Z, X -> INN
  - 4: MUL K, INN -> T
  - 5: ADD X, T -> X
  - 6: MUL K, PP -> T
  - 7: SUB PP, T -> P
- `au_R`, `au_S` and `au_op_sel` are decoded combinationally from the step counter. They are held stable through ISSUE and WAIT.
- States:
  - IDLE -> ISSUE on a measurement transfer.
  - ISSUE: `au_start` = 1 for exactly one cycle; -> WAIT.
  - WAIT: on `au_done`, write `au_result` to the step's destination at that edge. If step == 7 -> OUT; otherwise step += 1 and -> ISSUE.
  - OUT: `out_valid` = 1 for one cycle; -> IDLE.
- `au_done` outside WAIT is ignored; no register is written.
- The sequencer never relies on `au` latency; it waits for `au_done` without a timeout.
- Saturation and rounding are entirely `au`'s responsibility; results are stored verbatim.
- `x_out`/`p_out` are direct register outputs. They reflect X after step 5 and P after step 7, and config writes.

## Timing
- Reset values: state IDLE, step 0, all registers 0.
  - Outputs: `au_start` 0, `out_valid` 0, `busy` 0, `meas_ready` 1, `x_out`/`p_out` 0.
  - `au_op_sel` 00, `au_R`/`au_S` = P/Q decode of step 0, which are 0 after reset.
- Step latency: 1 (ISSUE) + A cycles, where A is the `au` start-to-done distance (2 for ADD/SUB/MUL in `au`).
- Accept edge at cycle 0 (transfer cycle):
  - ISSUE of step 0 is cycle 1.
  - With every step at A = 2, the last `au_done` falls in cycle 24 and `out_valid` in cycle 25.
  - With a DIV latency of L, `out_valid` falls in cycle 23 + L.
- `meas_ready` returns in the cycle after OUT.
- Reset mid-program: immediate return to IDLE with all registers cleared. `au` is reset from the same source at top level.

## Test plan
- Reset: assert `rst` mid-WAIT at step 4 -> same cycle: `busy` 0, `au_start` 0, `x_out` 0; `meas_ready` 1 after deassert.
- Nominal update with behavioural `au` (A = 2, L = 2): X = 0, P = 0x004000, Q = 0, R = 0x004000, z = 0x008000 -> `out_valid` exactly 25 cycles after accept, `x_out` 0x004000, `p_out` 0x002000.
- Sign path: same setup, z = 0x808000 -> `x_out` 0x804000, `p_out` 0x002000.
- Real `au`, DIV latency unknown: nominal update -> same outputs; `au_start` pulses exactly 8 times, each one cycle wide, never while `au` `busy`.
- Config priority: `cfg_we` (addr 2, 0x000100) with `meas_valid` in IDLE -> `meas_ready` 0, Q = 0x000100, measurement accepted next cycle. `cfg_we` during step 3 -> Q unchanged.
- Spurious `au_done` pulse in IDLE and in ISSUE -> no register changes; step does not advance; final outputs match the nominal case.
